// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

    // Widest operand the magnitude helper supports; div WIDTH must not exceed it.
    localparam int DIV_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } div_state_e;

    // Quotient returned for a zero divisor; sliced to WIDTH by the user.
    localparam logic [DIV_MAX_W-1:0] DIV_ZERO_Q = '1;

    // Caller sign-extends x from WIDTH; one spare bit above WIDTH keeps -2^(WIDTH-1) exact.
    function automatic logic [DIV_MAX_W-1:0] abs_ext(input logic [DIV_MAX_W-1:0] x,
                                                     input logic                 sgn);
        if (sgn && x[DIV_MAX_W-1]) begin
            return -x;
        end
        return x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor, keep if no borrow.
// Purely combinational; the top level registers the outputs once per ITER cycle.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] trial;

    // The shifted partial remainder needs one extra bit before the subtract.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor_i};
    assign trial   = WIDTH'(shifted - {1'b0, divisor_i});

    always_comb begin
        rem_o = shifted[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_o = trial;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// hold_o is high WIDTH+2 cycles for a normal divide, 1 cycle for zero-divisor/overflow; stall freezes all.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [WIDTH-1:0] first_operand_i,
    input  logic [WIDTH-1:0] second_operand_i,
    input  logic             signed_i,
    input  logic             rem_i,
    input  logic             enable_i,
    output logic             hold_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             sgn_q, sgn_d;
    logic             rem_sel_q, rem_sel_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             hold_q, hold_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]     step_rem, step_quo;
    logic                 a_neg, b_neg;
    logic [DIV_MAX_W-1:0] abs_a, abs_b;
    logic [WIDTH-1:0]     quo_fixed, rem_fixed;
    logic [2*(DIV_MAX_W-WIDTH)-1:0] unused_abs_hi;

    // In LOAD, quo_q/dvsr_q still hold the raw latched dividend/divisor.
    assign a_neg = sgn_q & quo_q[WIDTH-1];
    assign b_neg = sgn_q & dvsr_q[WIDTH-1];
    assign abs_a = abs_ext({{(DIV_MAX_W-WIDTH){a_neg}}, quo_q}, sgn_q);
    assign abs_b = abs_ext({{(DIV_MAX_W-WIDTH){b_neg}}, dvsr_q}, sgn_q);
    assign unused_abs_hi = {abs_a[DIV_MAX_W-1:WIDTH], abs_b[DIV_MAX_W-1:WIDTH]};

    assign quo_fixed = neg_quo_q ? -quo_q : quo_q;
    assign rem_fixed = neg_rem_q ? -rem_q : rem_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        sgn_d     = sgn_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hold_d    = hold_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (enable_i) begin
                    state_d   = LOAD;
                    quo_d     = first_operand_i;
                    dvsr_d    = second_operand_i;
                    sgn_d     = signed_i;
                    rem_sel_d = rem_i;
                    hold_d    = 1'b1;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (dvsr_q == '0) begin
                    state_d  = DONE;
                    hold_d   = 1'b0;
                    result_d = rem_sel_q ? quo_q : DIV_ZERO_Q[WIDTH-1:0];
                end else if (sgn_q && (quo_q == MIN_NEG) && (dvsr_q == '1)) begin
                    state_d  = DONE;
                    hold_d   = 1'b0;
                    result_d = rem_sel_q ? '0 : quo_q;
                end else begin
                    state_d   = ITER;
                    count_d   = '0;
                    rem_d     = '0;
                    quo_d     = abs_a[WIDTH-1:0];
                    dvsr_d    = abs_b[WIDTH-1:0];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                end
            end
            ITER: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d  = DONE;
                hold_d   = 1'b0;
                result_d = rem_sel_q ? rem_fixed : quo_fixed;
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b0;
            end
        endcase
    end

    // Reset is active-high despite its name; stall gates every register update.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            sgn_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hold_q    <= 1'b0;
            result_q  <= '0;
        end else if (!stall) begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            sgn_q     <= sgn_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hold_q    <= hold_d;
            result_q  <= result_d;
        end
    end

    assign hold_o   = hold_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vector table, stall/reset/back-to-back sequences, random vs model.
module tb_div;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [31:0] first_operand_i;
    logic [31:0] second_operand_i;
    logic        signed_i;
    logic        rem_i;
    logic        enable_i;
    logic        hold_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div #(.WIDTH(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .first_operand_i  (first_operand_i),
        .second_operand_i (second_operand_i),
        .signed_i         (signed_i),
        .rem_i            (rem_i),
        .enable_i         (enable_i),
        .hold_o           (hold_o),
        .result_o         (result_o)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        r;
        logic [31:0] exp_res;
        int          exp_hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero like RISC-V.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic r);
        longint q, m;
        logic [63:0] qv, mv;
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            m = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            m = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        qv = q;
        mv = m;
        return r ? mv[31:0] : qv[31:0];
    endfunction

    function automatic int ref_hold(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0) return 1;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issues one operation and counts hold_o cycles, sampling on the falling edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                          input bit b2b, input int st_at, input int st_len, input bit poke_en,
                          output int hcyc, output logic [31:0] res, output bit stable);
        logic [31:0] pre;
        int cyc;
        if (!b2b) @(negedge clk);
        first_operand_i  = a;
        second_operand_i = b;
        signed_i         = s;
        rem_i            = r;
        enable_i         = 1'b1;
        pre              = result_o;
        @(negedge clk);
        enable_i         = 1'b0;
        first_operand_i  = $urandom;
        second_operand_i = $urandom;
        signed_i         = ~s;
        rem_i            = ~r;
        hcyc   = 0;
        cyc    = 0;
        stable = 1'b1;
        while (hold_o && cyc < 300) begin
            if (result_o !== pre) stable = 1'b0;
            stall    = (cyc >= st_at) && (cyc < st_at + st_len);
            enable_i = poke_en && (cyc == 5);
            hcyc++;
            cyc++;
            @(negedge clk);
        end
        stall    = 1'b0;
        enable_i = 1'b0;
        if (cyc >= 300) begin
            errors++;
            checks++;
            $display("FAIL timeout: hold_o still %b after %0d cycles, required 0", hold_o, cyc);
        end
        res = result_o;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[12];
        int          hc;
        logic [31:0] res;
        bit          stb;
        logic [31:0] ra, rb;
        logic        rs, rr;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         34};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF,  34};
        vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD,  34};
        vecs[3]  = '{32'd42,         32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  1};
        vecs[4]  = '{32'd42,         32'd0,          1'b0, 1'b1, 32'd42,         1};
        vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000,  1};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0,          1};
        vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000,  34};
        vecs[8]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, 32'hFFFF_FFFD,  34};
        vecs[9]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b1, 32'd1,          34};
        vecs[10] = '{32'h8000_0000,  32'd1,          1'b1, 1'b0, 32'h8000_0000,  34};
        vecs[11] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 1'b1, 32'hFFFF_FFFB,  1};

        reset_n          = 1'b1;
        stall            = 1'b0;
        enable_i         = 1'b0;
        first_operand_i  = '0;
        second_operand_i = '0;
        signed_i         = 1'b0;
        rem_i            = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hold", {31'd0, hold_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        reset_n = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, 1'b0, 0, 0, 1'b0, hc, res, stb);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_hold", i), 32'(hc), 32'(vecs[i].exp_hold));
            chk($sformatf("vec%0d_stable", i), {31'd0, stb}, 32'd1);
        end

        // Stall for 5 cycles mid-ITER: latency grows by exactly 5, result untouched meanwhile.
        run_op(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, 10, 5, 1'b0, hc, res, stb);
        chk("stall_result", res, 32'd333);
        chk("stall_hold", 32'(hc), 32'd39);
        chk("stall_stable", {31'd0, stb}, 32'd1);

        // enable_i pulsed during ITER must be ignored.
        run_op(32'd12345, 32'd10, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, hc, res, stb);
        chk("poke_result", res, 32'd5);
        chk("poke_hold", 32'(hc), 32'd34);

        // Back-to-back: enable raised in DONE on the same cycle the previous result appears.
        run_op(32'd90, 32'd9, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, hc, res, stb);
        chk("b2b_result", res, 32'd10);
        chk("b2b_hold", 32'(hc), 32'd34);

        // Reset asserted at ITER count 10 aborts without a partial result.
        @(negedge clk);
        first_operand_i  = 32'd1000;
        second_operand_i = 32'd3;
        signed_i         = 1'b0;
        rem_i            = 1'b0;
        enable_i         = 1'b1;
        @(negedge clk);
        enable_i = 1'b0;
        repeat (11) @(negedge clk);
        chk("abort_busy", {31'd0, hold_o}, 32'd1);
        reset_n = 1'b1;
        #1;
        chk("abort_hold", {31'd0, hold_o}, 32'd0);
        chk("abort_result", result_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        run_op(32'd6, 32'd3, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, hc, res, stb);
        chk("after_abort_result", res, 32'd2);
        chk("after_abort_hold", 32'(hc), 32'd34);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: rb = $urandom;
            endcase
            if (i % 8 == 3) ra = 32'h8000_0000;
            if (i % 8 == 4) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            rs = $urandom_range(0, 1);
            rr = $urandom_range(0, 1);
            run_op(ra, rb, rs, rr, (i % 5 == 2), 0, 0, 1'b0, hc, res, stb);
            chk($sformatf("rand%0d_result(%h/%h s%0d r%0d)", i, ra, rb, rs, rr),
                res, ref_div(ra, rb, rs, rr));
            chk($sformatf("rand%0d_hold", i), 32'(hc), 32'(ref_hold(ra, rb, rs)));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
